// File: rtl/rv32v_types_pkg.sv
// Shared types for the vector decode-stage micro-op sequencer: SEW encoding,
// sequencer FSM states, lane count and the elements-per-register shift helper.
package rv32v_types_pkg;

    typedef enum logic [1:0] {
        SEW8  = 2'd0,
        SEW16 = 2'd1,
        SEW32 = 2'd2
    } sew_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } seq_state_t;

    localparam int VLEN_DEFAULT = 128;
    localparam int UOP_LANES    = 2;

    // log2 of element width in bits: elements per register = VLEN >> epr_shift(sew)
    function automatic logic [2:0] epr_shift(input sew_t sew);
        return 3'd3 + {1'b0, sew};
    endfunction

endpackage

// File: rtl/rv32v_elem_to_vreg.sv
// Maps an element index to its offset inside a vector register and the register
// index within the LMUL group, using only shifts and masks.
module rv32v_elem_to_vreg
    import rv32v_types_pkg::*;
#(
    parameter int VLEN  = VLEN_DEFAULT,
    parameter int IDX_W = $clog2(VLEN) + 1
) (
    input  logic [IDX_W-1:0] elem,
    input  sew_t             sew,
    output logic [IDX_W-1:0] woffset,
    output logic [2:0]       vreg_off
);

    localparam int LOG_VLEN = $clog2(VLEN);

    // log2(elements per register)
    logic [4:0]       shamt;
    logic [IDX_W-1:0] epr_mask;

    assign shamt    = 5'(LOG_VLEN) - {2'b00, epr_shift(sew)};
    assign epr_mask = (IDX_W'(1) << shamt) - IDX_W'(1);
    assign woffset  = elem & epr_mask;
    assign vreg_off = 3'(elem >> shamt);

endmodule

// File: rtl/rv32v_uop_sequencer.sv
// Splits one decoded vector instruction into two-element micro-ops for execute.
// Optional zero-bubble chaining of instructions: define RV32V_SEQ_BACK2BACK_EN.
module rv32v_uop_sequencer
    import rv32v_types_pkg::*;
#(
    parameter int VLEN  = VLEN_DEFAULT,
    parameter int IDX_W = $clog2(VLEN) + 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic [31:0]      vl,
    input  logic [31:0]      vstart,
    input  logic [1:0]       sew,
    input  logic             mask_en,
    input  logic [VLEN-1:0]  v0_bits,
    input  logic             stall,
    input  logic             flush,
    output logic             uop_valid,
    output logic [IDX_W-1:0] woffset0,
    output logic [IDX_W-1:0] woffset1,
    output logic [2:0]       vreg_off0,
    output logic [2:0]       vreg_off1,
    output logic             wen0,
    output logic             wen1,
    output logic             mask0,
    output logic             mask1,
    output logic             first_uop,
    output logic             last_uop,
    output logic             busy
);

    localparam int LOG_VLEN = $clog2(VLEN);

    seq_state_t       state_reg;
    logic [IDX_W-1:0] idx_reg;
    logic [IDX_W-1:0] vl_eff_reg;
    sew_t             sew_reg;
    logic             mask_en_reg;
    logic [VLEN-1:0]  v0_reg;
    logic             first_reg;

    logic             run;
    logic             last;
    logic             accept;
    logic [IDX_W-1:0] vl_eff_in;
    logic             skip;

    logic [IDX_W-1:0] elem     [UOP_LANES];
    logic [IDX_W-1:0] woff     [UOP_LANES];
    logic [2:0]       vreg     [UOP_LANES];
    logic             mask_bit [UOP_LANES];
    logic             wen_bit  [UOP_LANES];

    assign run  = (state_reg == RUN);
    assign last = ({1'b0, idx_reg} + (IDX_W+1)'(2)) >= {1'b0, vl_eff_reg};

`ifdef RV32V_SEQ_BACK2BACK_EN
    assign instr_ready = !flush && (!run || (last && !stall));
`else
    assign instr_ready = !flush && !run;
`endif

    assign accept    = instr_valid && instr_ready;
    assign vl_eff_in = (vl > 32'(VLEN)) ? IDX_W'(VLEN) : vl[IDX_W-1:0];
    assign skip      = vstart >= 32'(vl_eff_in);

    genvar gi;
    generate
        for (gi = 0; gi < UOP_LANES; gi++) begin : g_lane
            assign elem[gi] = idx_reg + IDX_W'(gi);

            rv32v_elem_to_vreg #(.VLEN(VLEN), .IDX_W(IDX_W)) u_map (
                .elem     (elem[gi]),
                .sew      (sew_reg),
                .woffset  (woff[gi]),
                .vreg_off (vreg[gi])
            );

            // elements past the end of v0 read as masked off
            assign mask_bit[gi] = mask_en_reg
                ? ((elem[gi] < IDX_W'(VLEN)) && v0_reg[elem[gi][LOG_VLEN-1:0]])
                : 1'b1;
            assign wen_bit[gi]  = (elem[gi] < vl_eff_reg) && mask_bit[gi];
        end
    endgenerate

    assign uop_valid = run;
    assign busy      = run;
    assign first_uop = run && first_reg;
    assign last_uop  = run && last;
    assign woffset0  = run ? woff[0] : '0;
    assign woffset1  = run ? woff[1] : '0;
    assign vreg_off0 = run ? vreg[0] : '0;
    assign vreg_off1 = run ? vreg[1] : '0;
    assign mask0     = run && mask_bit[0];
    assign mask1     = run && mask_bit[1];
    assign wen0      = run && wen_bit[0];
    assign wen1      = run && wen_bit[1];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_reg   <= IDLE;
            idx_reg     <= '0;
            vl_eff_reg  <= '0;
            sew_reg     <= SEW8;
            mask_en_reg <= 1'b0;
            v0_reg      <= '0;
            first_reg   <= 1'b0;
        end else if (flush) begin
            state_reg <= IDLE;
            first_reg <= 1'b0;
        end else if (accept) begin
            vl_eff_reg  <= vl_eff_in;
            sew_reg     <= sew_t'(sew);
            mask_en_reg <= mask_en;
            v0_reg      <= v0_bits;
            if (skip) begin
                state_reg <= IDLE;
                first_reg <= 1'b0;
            end else begin
                state_reg <= RUN;
                idx_reg   <= vstart[IDX_W-1:0];
                first_reg <= 1'b1;
            end
        end else if (run && !stall) begin
            idx_reg   <= idx_reg + IDX_W'(2);
            first_reg <= 1'b0;
            if (last) begin
                state_reg <= IDLE;
            end
        end
    end

endmodule
